// File: rtl/mem_responder.sv
// Word-addressed data-memory responder for the multicycle MIPS core's load/store port.
// Latency: ack is high WAIT_CYCLES+1 cycles after the req-sampling edge; one access per WAIT_CYCLES+2 cycles.
// Backpressure: one request in flight; req is ignored until the FSM returns to IDLE after the ack cycle.
// Optional feature: define MEM_RESP_MMIO_EN to map the cycle counter (0xFFFF_FF00) and gpio_out (0xFFFF_FF04).

module mem_responder #(
    parameter int ADDR_W      = 9,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        err,
    output logic        busy,
    output logic [7:0]  gpio_out
);

    localparam int       LP_DEPTH = 1 << ADDR_W;
    localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [3:0]         r_cnt;
    logic               r_we;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;

    logic [31:0]        r_rdata;
    logic               r_ack;
    logic               r_err;
    logic               r_busy;

    logic [31:0]        r_mem [LP_DEPTH];

    logic               w_we;
    logic [31:0]        w_addr;
    logic [31:0]        w_wdata;
    logic               w_enter_resp;
    logic               w_misal;
    logic               w_ram;
    logic               w_mmio;
    logic               w_err;
    logic [ADDR_W-1:0]  w_idx;
    logic [31:0]        w_rd;

`ifdef MEM_RESP_MMIO_EN
    logic [31:0]        r_cyc;
    logic [7:0]         r_gpio;
    logic               w_is_cyc;
    logic               w_is_gpio;
`endif

    // State register and request latch; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && req) begin
                r_we    <= we;
                r_addr  <= addr;
                r_wdata <= wdata;
                r_cnt   <= LP_WAIT;
            end else if (r_state == WAIT) begin
                r_cnt   <= r_cnt - 4'd1;
            end
        end
    end

    // Next-state logic: WAIT lasts exactly WAIT_CYCLES cycles, RESP exactly one.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (req) begin
                    w_next = (LP_WAIT == 4'd0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (r_cnt <= 4'd1) begin
                    w_next = RESP;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // With zero wait states the access happens on the capture edge itself, so the
    // live inputs are used while in IDLE and the latched copy otherwise.
    always_comb begin
        w_we    = r_we;
        w_addr  = r_addr;
        w_wdata = r_wdata;
        if (r_state == IDLE) begin
            w_we    = we;
            w_addr  = addr;
            w_wdata = wdata;
        end
    end

    // The commit/read edge is the one that moves the FSM into RESP; gated by
    // rst_n so nothing commits while reset is held.
    assign w_enter_resp = rst_n && (w_next == RESP) && (r_state != RESP);

    assign w_misal = (w_addr[1:0] != 2'b00);
    assign w_ram   = (w_addr[31:ADDR_W+2] == '0);
    assign w_idx   = w_addr[ADDR_W+1:2];

`ifdef MEM_RESP_MMIO_EN
    assign w_is_cyc  = (w_addr == 32'hFFFF_FF00);
    assign w_is_gpio = (w_addr == 32'hFFFF_FF04);
    assign w_mmio    = w_is_cyc | w_is_gpio;
`else
    assign w_mmio    = 1'b0;
`endif

    assign w_err = w_misal | ~(w_ram | w_mmio);

    // Read mux; error accesses always return zero.
    always_comb begin
        w_rd = 32'd0;
        if (!w_err) begin
            if (w_ram) begin
                w_rd = r_mem[w_idx];
            end
`ifdef MEM_RESP_MMIO_EN
            else if (w_is_cyc) begin
                w_rd = r_cyc;
            end else if (w_is_gpio) begin
                w_rd = {24'd0, r_gpio};
            end
`endif
        end
    end

    // Word storage write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_enter_resp && w_we && !w_err && w_ram) begin
            r_mem[w_idx] <= w_wdata;
        end
    end

    // Registered response outputs; rdata/err are cleared outside the ack cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= 32'd0;
            r_busy  <= 1'b0;
        end else begin
            r_ack   <= w_enter_resp;
            r_err   <= w_enter_resp ? w_err : 1'b0;
            r_rdata <= w_enter_resp ? w_rd : 32'd0;
            r_busy  <= (w_next != IDLE);
        end
    end

`ifdef MEM_RESP_MMIO_EN
    // Free-running cycle counter (wraps naturally) and GPIO output register;
    // stores to the counter address are dropped without error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cyc  <= 32'd0;
            r_gpio <= 8'd0;
        end else begin
            r_cyc <= r_cyc + 32'd1;
            if (w_enter_resp && w_we && !w_err && w_is_gpio) begin
                r_gpio <= w_wdata[7:0];
            end
        end
    end

    assign gpio_out = r_gpio;
`else
    assign gpio_out = 8'd0;
`endif

    assign rdata = r_rdata;
    assign ack   = r_ack;
    assign err   = r_err;
    assign busy  = r_busy;

endmodule

// File: doc/mem_responder.md
# mem_responder

Word-addressed data-memory responder that services load/store requests from the multicycle MIPS core over a req/ack handshake, replacing the zero-wait synchronous memory on the CPU's data port. It captures one request at a time, inserts a parameterized number of wait states, performs the access on internal word storage, and returns read data with a one-cycle acknowledge. Misaligned and out-of-range accesses are rejected with an error flag. An optional memory-mapped I/O window is also available.

## Interface
- ADDR_W, 9, word-address width; storage depth is 2^ADDR_W 32-bit words
- WAIT_CYCLES, 2, wait states between request capture and ack (0..15)
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req  input  1  request valid; initiator holds req, we, addr, wdata stable until ack
- we  input  1  1 = store word, 0 = load word
- addr  input  32  byte address from the CPU
- wdata  input  32  store data
- rdata  output  32  load data; valid only in the ack cycle
- ack  output  1  one-cycle completion pulse
- err  output  1  valid with ack; 1 = misaligned or unmapped access, no side effect
- busy  output  1  high from capture until the ack cycle, inclusive
- gpio_out  output  8  MMIO output register (0 when MMIO is compiled out)

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: if req, latch we/addr/wdata and load the wait counter with WAIT_CYCLES. Go to WAIT if WAIT_CYCLES>0, else RESP.
- WAIT: decrement the counter. Go to RESP when the counter reaches 1.
- RESP: assert ack. Drive rdata/err from the registered result. Return to IDLE unconditionally.
- req is ignored outside IDLE. A req still high in the cycle after ack is treated as a new request.
- Decode on the latched address:
  - misaligned when addr[1:0]!=0;
  - RAM when addr[31:ADDR_W+2]==0;
  - otherwise MMIO (if enabled) or unmapped.
- Error accesses (misaligned or unmapped): no write, rdata=0, err=1.
- Store: mem[addr[ADDR_W+1:2]] <= wdata, committed on the edge entering RESP. Load reads on that same edge.
- A load issued right after a store to the same word returns the new data.
- RAM contents are not reset.

## Timing
- Reset values: state=IDLE, ack=0, err=0, busy=0, rdata=0, gpio_out=0, cycle counter=0.
- Latency from the req-sampling edge to ack high is WAIT_CYCLES+1 cycles. With WAIT_CYCLES=0, ack is high the cycle after req is sampled.
- Throughput: one access per WAIT_CYCLES+2 cycles with back-to-back requests.
- ack and err are registered outputs, with no combinational path from req.
- busy rises on the capture edge and falls on the edge leaving RESP.
- Reset asserted mid-transaction aborts it immediately: no ack is issued, and a pending store is not committed unless its commit edge already occurred.
- WAIT_CYCLES is a 4-bit counter. Values above 15 are illegal.

## Configuration
- Macro: MEM_RESP_MMIO_EN.
- Defined: two MMIO words are mapped.
  - 0xFFFF_FF00: read-only 32-bit free-running cycle counter. It increments every clk, wraps 0xFFFF_FFFF→0, and stores to it are silently dropped with err=0.
  - 0xFFFF_FF04: gpio_out in bits [7:0]. Reads return {24'b0, gpio_out}; stores update gpio_out on the commit edge.
- Not defined: those addresses are unmapped (err=1), the counter is absent, and gpio_out is tied to 0.

## Test plan
- Reset then idle: all outputs 0, busy=0; req low for 10 cycles → no ack.
- WAIT_CYCLES=2: store 0xDEADBEEF to 0x0000_0010, then load 0x10.
  - ack occurs 3 cycles after each sampling edge;
  - the load returns 0xDEADBEEF with err=0.
- Misaligned store to 0x0000_0012 with wdata 0x1 → ack with err=1. A subsequent load of 0x10 still returns 0xDEADBEEF.
- Out-of-range load at 0x0000_0800 (ADDR_W=9) → err=1, rdata=0.
- Reset pulsed in WAIT during a store of 0x55 to 0x20:
  - no ack;
  - state IDLE after release;
  - a later load of 0x20 returns whatever was written before.
- MMIO_EN defined: store 0xA5 to 0xFFFF_FF04 → gpio_out=0xA5. Two loads of 0xFFFF_FF00 issued N cycles apart differ by N. Without the macro, the same store gives err=1 and gpio_out stays 0.
